// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// Latency: n/a (declarations only). Backpressure: n/a.
// Provides the FSM state encoding, the default operand width and the counter-width helper.
package mult_pkg;

    localparam int MULT_WIDTH = 6;

    // Keep at least one counter bit so that WIDTH=1 still elaborates.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(MULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// WIDTH-bit unsigned adder with carry-out, used for one partial-product step.
// Latency: combinational. Backpressure: none.
// The carry-out becomes the top bit of the shifted accumulator.
module shift_add_multiplier_adder #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    assign {cout, s} = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier; optional MULT_ZERO_BYPASS_EN skips RUN for zero operands.
// Latency: WIDTH+1 cycles from accepted start to done (1 cycle when bypassing).
// Backpressure: start is only accepted in IDLE or DONE; it is ignored while busy.
import mult_pkg::*;

module shift_add_multiplier #(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic               w_zero;
    logic               w_bypass;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_last;

`ifdef MULT_ZERO_BYPASS_EN
    assign w_zero = (a == '0) || (b == '0);
`else
    assign w_zero = 1'b0;
`endif

    shift_add_multiplier_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .x    (r_acc[2*WIDTH-1:WIDTH]),
        .y    (r_mcand),
        .s    (w_sum),
        .cout (w_cout)
    );

    // Upper half takes the add (or passes through), then the whole accumulator shifts right.
    assign w_acc_next = r_acc[0] ? {w_cout, w_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1:1]};
    assign w_last     = (r_cnt == LAST);
    assign w_bypass   = w_load && w_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = w_zero ? DONE : RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_load) begin
            r_mcand <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_cnt   <= '0;
            if (w_bypass) begin
                r_product <= '0;
            end
        end else if (r_state == RUN) begin
            r_acc <= w_acc_next;
            if (w_last) begin
                r_product <= w_acc_next;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);
    assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and exhaustive bench for shift_add_multiplier at WIDTH=6.
// Expected products are queued at start and popped when done pulses.
module tb_shift_add_multiplier;

    localparam int W = 6;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks = 0;
    int fails  = 0;
    logic [2*W-1:0] sb_q[$];

    always #5 clk = ~clk;

    shift_add_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a start pulse; returns 1ns after the sampling edge.
    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y, input bit push);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        a     = x;
        b     = y;
        start = 1'b1;
        if (push) sb_q.push_back(p);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int lat, output bit busy_seen);
        bit found;
        found     = 1'b0;
        lat       = 0;
        busy_seen = 1'b0;
        while (lat < max && !found) begin
            @(negedge clk);
            lat++;
            if (busy) busy_seen = 1'b1;
            if (done) found = 1'b1;
        end
        check("done_seen", 32'(found), 32'd1);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            check("busy_done_excl", 32'(busy), 32'd0);
            if (sb_q.size() != 0) check("sb_product", 32'(product), 32'(sb_q.pop_front()));
        end
    end

    initial begin
        int lat;
        bit bs;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 63*63 with cycle-exact busy/done timing
        do_start(6'd63, 6'd63, 1'b1);
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check("run_hold_product", 32'(product), 32'd0);
        end
        @(negedge clk);
        check("max_done", 32'(done), 32'd1);
        check("max_busy", 32'(busy), 32'd0);
        check("max_product", 32'(product), 32'd3969);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        // back-to-back: start in the done cycle
        do_start(6'd5, 6'd3, 1'b1);
        wait_done(20, lat, bs);
        check("b2b1_lat", 32'(lat), 32'd7);
        check("b2b1_product", 32'(product), 32'd15);
        do_start(6'd7, 6'd9, 1'b1);
        wait_done(20, lat, bs);
        check("b2b2_lat", 32'(lat), 32'd7);
        check("b2b2_busy_seen", 32'(bs), 32'd1);
        check("b2b2_product", 32'(product), 32'd63);

        // zero operand
        do_start(6'd0, 6'd45, 1'b1);
        wait_done(20, lat, bs);
`ifdef MULT_ZERO_BYPASS_EN
        check("zero_lat", 32'(lat), 32'd1);
        check("zero_busy_seen", 32'(bs), 32'd0);
`else
        check("zero_lat", 32'(lat), 32'd7);
        check("zero_busy_seen", 32'(bs), 32'd1);
`endif
        check("zero_product", 32'(product), 32'd0);
        @(negedge clk);

        // start and operand changes during RUN are ignored
        do_start(6'd10, 6'd12, 1'b1);
        @(negedge clk);
        @(negedge clk);
        a     = 6'd1;
        b     = 6'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(20, lat, bs);
        check("ignore_lat", 32'(lat), 32'd5);
        check("ignore_product", 32'(product), 32'd120);
        @(negedge clk);

        // reset mid-RUN aborts
        do_start(6'd33, 6'd17, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        do_start(6'd2, 6'd2, 1'b1);
        wait_done(20, lat, bs);
        check("post_rst_lat", 32'(lat), 32'd7);
        check("post_rst_product", 32'(product), 32'd4);

        // exhaustive back-to-back sweep; products checked by the scoreboard
        for (int i = 0; i < 64; i++) begin
            for (int j = 0; j < 64; j++) begin
                do_start(W'(i), W'(j), 1'b1);
                wait_done(20, lat, bs);
            end
        end
        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
